// File: rtl/eflash_readout_serializer.sv
// Latches both eFlash sense buses on a strobe and streams them out as
// WORD_W-bit words over a valid/ready handshake, flagging overlapping captures.
module eflash_readout_serializer #(
    parameter  int WORD_W    = 32,
    parameter  int LINE_W    = 1024,
    localparam int NUM_WORDS = 2 * LINE_W / WORD_W,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              capture_i,
    input  logic [LINE_W-1:0] eFlash_output_1_i,
    input  logic [LINE_W-1:0] eFlash_output_2_i,
    input  logic              flush_i,
    input  logic              clr_overrun_i,
    input  logic              ready_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    output logic [IDX_W-1:0]  word_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t                state_q, state_d;
    logic [2*LINE_W-1:0]   buf_q, buf_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic                  ovr_event;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        ovr_event = 1'b0;

        case (state_q)
            IDLE: begin
                if (capture_i && !flush_i) begin
                    buf_d   = {eFlash_output_2_i, eFlash_output_1_i};
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                ovr_event = capture_i;
                if (flush_i) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else if (valid_q && ready_i) begin
                    // Last word: hold the index rather than wrapping.
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                ovr_event = capture_i;
                idx_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        ovr_d = ovr_q;
        if (clr_overrun_i) begin
            ovr_d = 1'b0;
        end
        if (ovr_event) begin
            ovr_d = 1'b1;
        end

        // Output flags are decoded from the next state so they land registered.
        valid_d = (state_d == STREAM);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o     = valid_q ? buf_q[idx_q*WORD_W +: WORD_W] : '0;
    assign valid_o    = valid_q;
    assign word_idx_o = idx_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = ovr_q;

endmodule

// File: tb/tb_eflash_readout_serializer.sv
// Scoreboard bench for eflash_readout_serializer: stimulus pushes expected
// words, a negedge monitor pops and compares on every accepted transfer.
module tb_eflash_readout_serializer;

    localparam int WORD_W    = 32;
    localparam int LINE_W    = 1024;
    localparam int NUM_WORDS = 64;
    localparam int IDX_W     = 6;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              capture_i = 1'b0;
    logic [LINE_W-1:0] eFlash_output_1_i = '0;
    logic [LINE_W-1:0] eFlash_output_2_i = '0;
    logic              flush_i = 1'b0;
    logic              clr_overrun_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [WORD_W-1:0] data_o;
    logic              valid_o;
    logic [IDX_W-1:0]  word_idx_o;
    logic              busy_o;
    logic              done_o;
    logic              overrun_o;

    eflash_readout_serializer #(.WORD_W(WORD_W), .LINE_W(LINE_W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .capture_i         (capture_i),
        .eFlash_output_1_i (eFlash_output_1_i),
        .eFlash_output_2_i (eFlash_output_2_i),
        .flush_i           (flush_i),
        .clr_overrun_i     (clr_overrun_i),
        .ready_i           (ready_i),
        .data_o            (data_o),
        .valid_o           (valid_o),
        .word_idx_o        (word_idx_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .overrun_o         (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] build_bus(input logic [31:0] base);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int i = 0; i < LINE_W / WORD_W; i++) v[i*WORD_W +: WORD_W] = base + 32'(i);
        return v;
    endfunction

    // Monitor: pops on each transfer and checks stall stability.
    logic              prev_stall = 1'b0;
    logic              prev_flush = 1'b0;
    logic [WORD_W-1:0] prev_data  = '0;
    logic [IDX_W-1:0]  prev_idx   = '0;

    always @(negedge clk_i) begin
        exp_t e;
        if (prev_stall && !prev_flush && !rst_i) begin
            check("stall_valid_held", 64'(valid_o), 64'd1);
            if (valid_o) begin
                check("stall_data_stable", 64'(data_o), 64'(prev_data));
                check("stall_idx_stable", 64'(word_idx_o), 64'(prev_idx));
            end
        end
        if (valid_o && ready_i && !rst_i) begin
            xfers++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(data_o), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("word_data", 64'(data_o), 64'(e.data));
                check("word_idx", 64'(word_idx_o), 64'(e.idx));
            end
        end
        prev_stall = valid_o && !ready_i;
        prev_flush = flush_i;
        prev_data  = data_o;
        prev_idx   = word_idx_o;
    end

    task automatic push_words(input logic [31:0] b1, input logic [31:0] b2);
        exp_t e;
        for (int i = 0; i < NUM_WORDS; i++) begin
            e.idx  = IDX_W'(i);
            e.data = (i < 32) ? b1 + 32'(i) : b2 + 32'(i - 32);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic do_capture(input logic [31:0] b1, input logic [31:0] b2, input bit expect_it);
        eFlash_output_1_i = build_bus(b1);
        eFlash_output_2_i = build_bus(b2);
        capture_i = 1'b1;
        if (expect_it) push_words(b1, b2);
        @(posedge clk_i); #1;
        capture_i = 1'b0;
    endtask

    task automatic wait_idx(input int target);
        bit found;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk_i); #1;
            if (valid_o && word_idx_o == IDX_W'(target)) found = 1;
        end
        check("wait_idx_reached", 64'(found), 64'd1);
    endtask

    task automatic wait_done(input bit rnd_ready);
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk_i); #1;
            if (rnd_ready) ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            if (done_o) seen = 1;
        end
        check("done_seen", 64'(seen), 64'd1);
        ready_i = 1'b1;
    endtask

    initial begin
        int x0;
        // Reset state
        #12;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ovr", 64'(overrun_o), 64'd0);
        check("rst_idx", 64'(word_idx_o), 64'd0);
        check("rst_data", 64'(data_o), 64'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // 1: back-to-back stream, exact done/busy timing
        ready_i = 1'b1;
        do_capture(32'h1000_0000, 32'h2000_0000, 1);
        for (int i = 0; i < NUM_WORDS; i++) begin
            @(negedge clk_i);
            check("t1_valid_stream", 64'(valid_o), 64'd1);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("t1_done_pulse", 64'(done_o), 64'd1);
        check("t1_done_valid", 64'(valid_o), 64'd0);
        check("t1_done_busy", 64'(busy_o), 64'd1);
        check("t1_done_data", 64'(data_o), 64'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("t1_done_drop", 64'(done_o), 64'd0);
        check("t1_busy_drop", 64'(busy_o), 64'd0);
        check("t1_idx_zero", 64'(word_idx_o), 64'd0);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: random backpressure
        @(posedge clk_i); #1;
        x0 = xfers;
        do_capture(32'h1000_0000, 32'h2000_0000, 1);
        wait_done(1);
        check("t2_xfer_count", 64'(xfers - x0), 64'd64);
        check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: overrun while streaming
        @(posedge clk_i); #1;
        do_capture(32'h3000_0000, 32'h4000_0000, 1);
        wait_idx(10);
        do_capture(32'hA000_0000, 32'hB000_0000, 0);
        check("t3_ovr_set", 64'(overrun_o), 64'd1);
        wait_done(0);
        check("t3_ovr_after_done", 64'(overrun_o), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
        check("t3_ovr_sticky", 64'(overrun_o), 64'd1);
        do_capture(32'h5000_0000, 32'h6000_0000, 1);
        check("t3_ovr_idle_cap", 64'(overrun_o), 64'd1);
        wait_idx(5);
        clr_overrun_i = 1'b1;
        do_capture(32'hC000_0000, 32'hD000_0000, 0);
        clr_overrun_i = 1'b0;
        check("t3_set_beats_clr", 64'(overrun_o), 64'd1);
        clr_overrun_i = 1'b1;
        @(posedge clk_i); #1;
        clr_overrun_i = 1'b0;
        check("t3_ovr_cleared", 64'(overrun_o), 64'd0);
        wait_done(0);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: flush mid-stream; word 20 still accepted
        @(posedge clk_i); #1;
        do_capture(32'h7000_0000, 32'h8000_0000, 1);
        wait_idx(20);
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("t4_words_left", 64'(exp_q.size()), 64'd43);
        exp_q.delete();
        check("t4_valid_drop", 64'(valid_o), 64'd0);
        check("t4_busy_drop", 64'(busy_o), 64'd0);
        check("t4_idx_zero", 64'(word_idx_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("t4_no_done", 64'(done_o), 64'd0);
        end
        @(posedge clk_i); #1;
        do_capture(32'h1100_0000, 32'h2200_0000, 1);
        check("t4_restart_idx", 64'(word_idx_o), 64'd0);
        check("t4_restart_data", 64'(data_o), 64'h1100_0000);
        wait_done(0);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: asynchronous reset between edges
        @(posedge clk_i); #1;
        do_capture(32'h1300_0000, 32'h2300_0000, 1);
        wait_idx(40);
        #2;
        rst_i = 1'b1;
        #1;
        check("t5_rst_valid", 64'(valid_o), 64'd0);
        check("t5_rst_busy", 64'(busy_o), 64'd0);
        check("t5_rst_idx", 64'(word_idx_o), 64'd0);
        check("t5_rst_data", 64'(data_o), 64'd0);
        check("t5_rst_done", 64'(done_o), 64'd0);
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("t5_idle_busy", 64'(busy_o), 64'd0);
        do_capture(32'h1400_0000, 32'h2400_0000, 1);
        wait_done(0);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // 6: capture with flush in IDLE
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        flush_i = 1'b1;
        do_capture(32'hEE00_0000, 32'hFF00_0000, 0);
        flush_i = 1'b0;
        check("t6_valid_low", 64'(valid_o), 64'd0);
        check("t6_busy_low", 64'(busy_o), 64'd0);
        check("t6_ovr_low", 64'(overrun_o), 64'd0);
        @(posedge clk_i); #1;
        check("t6_valid_low2", 64'(valid_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/eflash_readout_serializer.md
Name: eflash_readout_serializer

Overview:
- Downstream consumer of the eFlash macro's two 1024-bit sense/ADC output buses, in the peripheral readout path.
- Captures both buses on a single strobe into a local line buffer.
- Returns the buffer to the RISC-V side as a stream of 32-bit words with a valid/ready handshake.
- Flags captures that arrive while a previous readout is still streaming.

Parameters:
- WORD_W, 32, width of each output word.
- LINE_W, 1024, width of each eFlash output bus. Must be a multiple of WORD_W.
- NUM_WORDS, 2*LINE_W/WORD_W (64), total words per readout. Derived; not overridable.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- capture_i  input  1  single-cycle strobe; latches both eFlash buses.
- eFlash_output_1_i  input  LINE_W  first eFlash output bus.
- eFlash_output_2_i  input  LINE_W  second eFlash output bus.
- flush_i  input  1  abort the current readout and return to IDLE.
- clr_overrun_i  input  1  clears the sticky overrun flag.
- ready_i  input  1  consumer accepts data_o this cycle.
- data_o  output  WORD_W  current word.
- valid_o  output  1  data_o is valid.
- word_idx_o  output  $clog2(NUM_WORDS)  index of the current word.
- busy_o  output  1  high in STREAM and DONE.
- done_o  output  1  one-cycle pulse after the last word transfers.
- overrun_o  output  1  sticky: a capture arrived while busy.

Behaviour:
- Reset: the following are all 0 asynchronously.
  - Line buffer (2*LINE_W bits) and word index.
  - data_o, valid_o, word_idx_o, busy_o, done_o, overrun_o.
  - FSM state = IDLE.
- The FSM has three states: IDLE, STREAM and DONE.
- IDLE:
  - capture_i=1 and flush_i=0: on that edge, buffer[LINE_W-1:0] <= eFlash_output_1_i and buffer[2*LINE_W-1:LINE_W] <= eFlash_output_2_i. Index is set to 0 and the state goes to STREAM.
  - capture_i together with flush_i: flush wins. Nothing is captured and overrun_o is not set.
- STREAM:
  - valid_o=1. data_o = buffer[idx*WORD_W +: WORD_W], so words 0..31 come from bus 1 LSB-first and words 32..63 from bus 2.
  - Latency: capture on edge N makes valid_o and word 0 visible from edge N onward, i.e. in the cycle after the strobe.
  - A transfer happens when valid_o && ready_i. On a transfer, idx increments on the next edge.
  - A transfer at idx = NUM_WORDS-1 moves the state to DONE. The index is not incremented (no wrap) and holds at NUM_WORDS-1.
  - While ready_i=0, data_o and word_idx_o hold stable and valid_o stays high. Valid must not drop without a transfer, except on flush or reset.
- DONE:
  - Lasts exactly one cycle: done_o=1, valid_o=0, busy_o=1.
  - Then the state goes to IDLE and the index resets to 0.
- When valid_o=0, data_o is driven to 0.
- busy_o=1 in STREAM and DONE; 0 in IDLE.
- capture_i in STREAM or DONE: the buffer is NOT modified and overrun_o <= 1. The stream continues unaffected.
- flush_i in STREAM or DONE:
  - Next state is IDLE, index goes to 0, valid_o drops next cycle, and no done_o pulse is produced.
  - The buffer contents are retained.
  - A transfer in the same cycle as flush is still counted as accepted by the consumer, but the stream ends.
- overrun_o:
  - Set by an overrun event; cleared by clr_overrun_i.
  - If both occur in the same cycle, set wins.
- Reset asserted mid-stream: immediate return to IDLE with all outputs 0. No done_o pulse.
- Outputs valid_o, busy_o, done_o and word_idx_o are registered (state decoded from flops). data_o is a mux of registered buffer and index.

Test Plan:
- Reset, then capture_i with bus1 = {32{32'h1000_0000 + i}} (word i = 0x1000_0000+i) and bus2 words = 0x2000_0000+i. Hold ready_i=1 -> 64 back-to-back words: 0x10000000..0x1000001F, then 0x20000000..0x2000001F. done_o pulses exactly one cycle after word 63; busy_o falls the cycle after.
- Same capture, with ready_i toggled by a random 50% pattern -> identical word sequence; data_o and word_idx_o stable while ready_i=0; total transfers = 64.
- capture_i again at word 10 with different bus data -> overrun_o=1; words 10..63 still from the first capture. overrun_o stays high after done_o until clr_overrun_i. clr_overrun_i together with a new overrun capture -> stays 1.
- flush_i at word 20 -> valid_o=0 next cycle, no done_o, busy_o=0. A fresh capture then starts again at word 0 with the new data.
- rst_i asserted asynchronously mid-stream at word 40 (between clock edges) -> all outputs 0 immediately; after release, IDLE, and a new capture works normally.
- capture_i and flush_i in the same cycle in IDLE -> no capture, valid_o stays 0, overrun_o stays 0.
